sram_1r1w_masked_init: RTL
==========================

# sram_1r1w_masked_init

Parametrised one-read/one-write masked SRAM model with a hardware initialisation sequencer, valid/ready request ports, write-to-read bypass and optional read-data hold. It is the next generation of the single-port masked array models: separate read and write ports, and arbitrary depth, width and mask segmentation. After reset it guarantees an all-zero array. It sits under the cache, TLB and predictor array templates, which use `init_done` to gate their own traffic.

## Interface
Parameters:
- `DEPTH`, 256, number of entries; any value ≥ 2, not required to be a power of two.
- `WIDTH`, 192, data bits per entry.
- `MASK_SEG`, 8, write-mask bits; `WIDTH` must be divisible by `MASK_SEG`; segment width `G = WIDTH/MASK_SEG`.
- `ADDR_W`, `$clog2(DEPTH)`, address width.
- `BYPASS`, 1, 1 = same-address read returns the data being written in the same cycle.
- `HOLD_READ`, 1, 1 = `r_data` holds the last read result until the next read fires.

Ports:
- `clock`  in  1  sole clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `r_valid`  in  1  read request.
- `r_ready`  out  1  read port accepts; equals `init_done`.
- `r_addr`  in  `ADDR_W`  read address.
- `r_resp_valid`  out  1  `r_data` carries a fresh result this cycle.
- `r_data`  out  `WIDTH`  read data.
- `w_valid`  in  1  write request.
- `w_ready`  out  1  write port accepts; equals `init_done`.
- `w_addr`  in  `ADDR_W`  write address.
- `w_mask`  in  `MASK_SEG`  bit i enables `w_data[i*G +: G]`.
- `w_data`  in  `WIDTH`  write data.
- `init_done`  out  1  initialisation complete.

## Operation
- FSM states:
  - INIT: entered asynchronously on reset; `init_cnt` = 0.
  - READY: normal operation.
- INIT behaviour: each rising edge writes all-zero to entry `init_cnt`, then increments `init_cnt`. The edge that writes entry `DEPTH-1` also moves the FSM to READY. No other exit path.
- Requests in INIT: `r_ready` = `w_ready` = 0, and requests have no effect.
- Fire conditions: a read fires on `r_valid && r_ready`; a write fires on `w_valid && w_ready`. Both ports are independent and may fire in the same cycle.
- Write: for each set `w_mask[i]`, segment i of entry `w_addr` is updated. Unmasked segments are preserved. `w_mask` = 0 is a legal no-op.
- Read: captures `r_addr`. The result is presented one cycle later with `r_resp_valid` = 1 for exactly that cycle.
- Out-of-range address (≥ `DEPTH`):
  - a write is dropped;
  - a read still gives `r_resp_valid` = 1, with `r_data` = 0.
- Read and write firing in the same cycle to the same in-range address:
  - `BYPASS=1`: each segment of the result is the new data if its mask bit is set, otherwise the old data.
  - `BYPASS=0`: the result is the old data.
- `HOLD_READ=1`: `r_data` is a register loaded only when a read result is produced. It keeps that value through later writes to the same address and through idle cycles.
- `HOLD_READ=0`: `r_data` = array[captured address], re-evaluated every cycle, so later writes to that entry become visible. The captured address is updated only by fired reads.
- Reset mid-operation, asynchronous:
  - FSM goes to INIT, `init_cnt` = 0;
  - `r_resp_valid`, `r_data` hold register and captured address go to 0;
  - array contents are left as they are and then overwritten by the re-init.

## Timing
- Reset values: `r_ready` = 0, `w_ready` = 0, `init_done` = 0, `r_resp_valid` = 0, `r_data` = 0.
- Init duration: `init_done` rises exactly `DEPTH` rising edges after reset deasserts. It is combinationally derived from the state (READY), and `r_ready`/`w_ready` equal it.
- Read latency: 1 cycle. A read fired at edge N gives `r_resp_valid` high between edges N and N+1. Back-to-back reads sustain one result per cycle.
- Write latency: a write fired at edge N is visible to a read fired at edge N+1 regardless of `BYPASS`. Same-edge visibility is governed by `BYPASS`.
- No combinational path from any input to any output.

## Test plan
- Init sweep (`DEPTH=256`): release reset → `init_done` = 0 for 255 edges and = 1 after edge 256; then reading every address returns 0.
- Masked write (`DEPTH=256`, `WIDTH=192`, `MASK_SEG=8`): write all-ones to addr 5 with mask 8'hFF, then 0 with mask 8'b0000_0101, then read addr 5 → `r_data` = 192'hFFFF…FF with bits [23:0] and [71:48] cleared; `r_resp_valid` = 1 for one cycle.
- Same-cycle collision: addr 9 holds 0; read and write (data all-ones, mask 8'h0F) fire together → `BYPASS=1` returns lower 96 bits = 1 and upper 96 bits = 0; `BYPASS=0` returns 0.
- Hold vs. no-hold: read addr 3 (value A), then write B to addr 3 and idle → `HOLD_READ=1` keeps `r_data` = A; `HOLD_READ=0` shows B from the cycle after the write.
- Out-of-range (`DEPTH=200`): write to addr 250 then read addr 250 → `r_data` = 0; entries 0–199 unchanged.
- Reset mid-init and mid-traffic: assert reset at init edge 100 and again during streaming reads → outputs return to reset values immediately; full `DEPTH`-cycle init restarts; a previously written entry reads 0 afterwards.

Source files
------------

// File: rtl/sram_1r1w_masked_init_if.sv
// ---------------------------------------------------------------------------
// sram_1r1w_masked_init_if
// Request/response bundle for the 1R1W masked SRAM model.
//   master : requester side (cache/TLB/predictor template) drives read and
//            write requests, observes ready, read response and init_done.
//   slave  : array side, the opposite directions.
// Signals:
//   r_valid/r_ready/r_addr        read request handshake and address
//   r_resp_valid/r_data           one-cycle-later read response
//   w_valid/w_ready/w_addr        write request handshake and address
//   w_mask/w_data                 per-segment write enables and write data
//   init_done                     array initialisation complete
// ---------------------------------------------------------------------------
interface sram_1r1w_masked_init_if #(
    parameter int ADDR_W   = 8,
    parameter int WIDTH    = 192,
    parameter int MASK_SEG = 8
);
    logic                r_valid;
    logic                r_ready;
    logic [ADDR_W-1:0]   r_addr;
    logic                r_resp_valid;
    logic [WIDTH-1:0]    r_data;
    logic                w_valid;
    logic                w_ready;
    logic [ADDR_W-1:0]   w_addr;
    logic [MASK_SEG-1:0] w_mask;
    logic [WIDTH-1:0]    w_data;
    logic                init_done;

    modport master (
        output r_valid, r_addr, w_valid, w_addr, w_mask, w_data,
        input  r_ready, r_resp_valid, r_data, w_ready, init_done
    );

    modport slave (
        input  r_valid, r_addr, w_valid, w_addr, w_mask, w_data,
        output r_ready, r_resp_valid, r_data, w_ready, init_done
    );
endinterface

// File: rtl/sram_1r1w_masked_init.sv
// ---------------------------------------------------------------------------
// sram_1r1w_masked_init
// One-read/one-write masked SRAM model with a hardware zero-initialisation
// sequencer. After reset every entry is cleared, one per clock, before the
// ports accept traffic (init_done). Reads return data one cycle after they
// fire; an optional same-cycle write bypass and an optional read-data hold
// register select the collision and idle behaviour.
// Ports:
//   clock  : sole clock, rising edge
//   reset  : asynchronous, active-high
//   bus    : slave side of sram_1r1w_masked_init_if (read/write requests,
//            read response, init_done)
// ---------------------------------------------------------------------------
module sram_1r1w_masked_init #(
    parameter int DEPTH     = 256,
    parameter int WIDTH     = 192,
    parameter int MASK_SEG  = 8,
    parameter int ADDR_W    = $clog2(DEPTH),
    parameter bit BYPASS    = 1'b1,
    parameter bit HOLD_READ = 1'b1
) (
    input  logic                          clock,
    input  logic                          reset,
    sram_1r1w_masked_init_if.slave        bus
);

    localparam int                G         = WIDTH / MASK_SEG;
    // One extra bit so DEPTH itself is representable for the range compare.
    localparam logic [ADDR_W:0]   DEPTH_L   = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    typedef enum logic [0:0] {
        ST_INIT  = 1'b0,
        ST_READY = 1'b1
    } state_e;

    state_e              state_q;
    logic [ADDR_W-1:0]   init_cnt_q;
    logic [WIDTH-1:0]    mem_q [DEPTH];

    logic                resp_valid_q, resp_valid_d;
    logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
    logic [WIDTH-1:0]    hold_data_q, hold_data_d;

    logic                ready_s;
    logic                init_wr_s;
    logic                rd_fire_s;
    logic                wr_fire_s;
    logic                rd_in_range_s;
    logic                wr_in_range_s;
    logic                live_in_range_s;
    logic [WIDTH-1:0]    rd_old_s;
    logic [WIDTH-1:0]    rd_result_s;
    logic [WIDTH-1:0]    wr_merged_s;
    logic [WIDTH-1:0]    live_data_s;

    // Replace the segments selected by mask with new_data, keep the rest.
    function automatic logic [WIDTH-1:0] merge_segments(
        input logic [WIDTH-1:0]    old_data,
        input logic [WIDTH-1:0]    new_data,
        input logic [MASK_SEG-1:0] mask
    );
        logic [WIDTH-1:0] res;
        res = old_data;
        for (int i = 0; i < MASK_SEG; i++) begin
            if (mask[i]) begin
                res[i*G +: G] = new_data[i*G +: G];
            end else begin
                res[i*G +: G] = old_data[i*G +: G];
            end
        end
        return res;
    endfunction

    assign ready_s = (state_q == ST_READY);
    // The sequencer must not touch the array while reset is held, so that
    // contents only change once the re-init sweep actually runs.
    assign init_wr_s = (state_q == ST_INIT) && !reset;

    // Request qualification, range checks and read-result selection.
    always_comb begin
        rd_fire_s     = bus.r_valid && ready_s;
        wr_fire_s     = bus.w_valid && ready_s;
        rd_in_range_s = ({1'b0, bus.r_addr} < DEPTH_L);
        wr_in_range_s = ({1'b0, bus.w_addr} < DEPTH_L);
        wr_merged_s   = merge_segments(mem_q[bus.w_addr], bus.w_data, bus.w_mask);
        if (rd_in_range_s) begin
            rd_old_s = mem_q[bus.r_addr];
        end else begin
            rd_old_s = '0;
        end
        if (BYPASS && wr_fire_s && wr_in_range_s && rd_in_range_s &&
            (bus.w_addr == bus.r_addr)) begin
            rd_result_s = merge_segments(rd_old_s, bus.w_data, bus.w_mask);
        end else begin
            rd_result_s = rd_old_s;
        end
    end

    // Next state of the read-response registers; only a fired read loads them.
    always_comb begin
        resp_valid_d = rd_fire_s;
        if (rd_fire_s) begin
            rd_addr_d   = bus.r_addr;
            hold_data_d = rd_result_s;
        end else begin
            rd_addr_d   = rd_addr_q;
            hold_data_d = hold_data_q;
        end
    end

    // Live view of the captured entry, used when the hold register is off.
    always_comb begin
        live_in_range_s = ({1'b0, rd_addr_q} < DEPTH_L);
        if (live_in_range_s) begin
            live_data_s = mem_q[rd_addr_q];
        end else begin
            live_data_s = '0;
        end
    end

    // Init/ready FSM: sweep every entry once, then stay ready until reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= ST_INIT;
            init_cnt_q <= '0;
        end else begin
            case (state_q)
                ST_INIT: begin
                    if (init_cnt_q == LAST_ADDR) begin
                        state_q    <= ST_READY;
                        init_cnt_q <= '0;
                    end else begin
                        state_q    <= ST_INIT;
                        init_cnt_q <= init_cnt_q + ADDR_W'(1);
                    end
                end
                ST_READY: begin
                    state_q    <= ST_READY;
                    init_cnt_q <= init_cnt_q;
                end
                default: begin
                    state_q    <= ST_INIT;
                    init_cnt_q <= '0;
                end
            endcase
        end
    end

    // Array storage: not reset, cleared by the sequencer, written by masked writes.
    always_ff @(posedge clock) begin
        if (init_wr_s) begin
            mem_q[init_cnt_q] <= '0;
        end else if (wr_fire_s && wr_in_range_s) begin
            mem_q[bus.w_addr] <= wr_merged_s;
        end
    end

    // Read-response registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            resp_valid_q <= 1'b0;
            rd_addr_q    <= '0;
            hold_data_q  <= '0;
        end else begin
            resp_valid_q <= resp_valid_d;
            rd_addr_q    <= rd_addr_d;
            hold_data_q  <= hold_data_d;
        end
    end

    assign bus.r_ready      = ready_s;
    assign bus.w_ready      = ready_s;
    assign bus.init_done    = ready_s;
    assign bus.r_resp_valid = resp_valid_q;
    assign bus.r_data       = HOLD_READ ? hold_data_q : live_data_s;

endmodule
